// File: rtl/nasti_master_pkg.sv
// ----------------------------------------------------------------------------
// nasti_master_pkg
//   Shared types and helpers for nasti_burst_master:
//     state_t      - master FSM states
//     RESP_*       - NASTI response encodings (ordered so a larger value is worse)
//     BURST_INCR   - the only burst type this master issues
//     crosses_4k() - true if a burst runs past the end of its 4 KB page
//     max_resp()   - worst of two responses
// ----------------------------------------------------------------------------
package nasti_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    // The sum is kept at 17 bits so that no legal-looking combination of
    // offset, length and size can wrap and hide a crossing: 256 beats of
    // 128 bytes plus a 4095-byte offset still fits.
    function automatic logic crosses_4k(input logic [11:0] offset,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size);
        logic [16:0] bytes;
        logic [16:0] end_addr;
        bytes    = ({9'd0, len} + 17'd1) << size;
        end_addr = {5'd0, offset} + bytes;
        return end_addr > 17'd4096;
    endfunction

    function automatic logic [1:0] max_resp(input logic [1:0] a,
                                            input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nasti_channel.sv
// ----------------------------------------------------------------------------
// nasti_channel
//   NASTI (AXI4-style) bundle of the five channels AW, W, B, AR, R.
//   modport master : drives AW/W/AR payload+valid and B/R ready
//   modport slave  : the mirror image
// ----------------------------------------------------------------------------
interface nasti_channel #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
);
    // write address
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    // write data
    logic                    w_valid;
    logic                    w_ready;
    logic [ID_WIDTH-1:0]     w_id;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    // write response
    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    // read address
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    // read data
    logic                    r_valid;
    logic                    r_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        input  aw_ready,
        output w_valid, w_id, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        output aw_ready,
        input  w_valid, w_id, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

endinterface

// File: rtl/nasti_burst_master.sv
// ----------------------------------------------------------------------------
// nasti_burst_master
//   Single-outstanding NASTI master. Accepts one burst command at a time,
//   checks it locally (beat size, 4 KB page crossing), then runs either an
//   AR/R read or an AW/W/B write and reports a one-cycle completion pulse
//   with the worst response seen and an error flag.
//
//   clk, rst            clock; asynchronous active-high reset
//   cmd_*               command handshake: write, id, addr, len (beats-1), size
//   wd_*                write beat stream (passed straight through to W)
//   rd_*                read beat stream (passed straight through from R)
//   done_valid          one-cycle completion pulse
//   done_resp/done_err  result of the last command, held until the next one
//                       is checked
//   nasti               NASTI master port
// ----------------------------------------------------------------------------
module nasti_burst_master
    import nasti_master_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic                    done_err,
    nasti_channel.master            nasti
);

    localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH / 8));

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [7:0]            beat_q;
    logic [1:0]            resp_q;
    logic                  err_q;

    logic chk_err;
    logic last_beat;
    logic cmd_fire;
    logic r_fire;
    logic w_fire;
    logic b_fire;
    logic r_proto_err;

    assign chk_err   = (size_q > SIZE_MAX) || crosses_4k(addr_q[11:0], len_q, size_q);
    assign last_beat = (beat_q == len_q);
    assign cmd_fire  = (state_q == ST_IDLE) && cmd_valid && !rst;
    assign r_fire    = (state_q == ST_R) && nasti.r_valid && rd_ready;
    assign w_fire    = (state_q == ST_W) && wd_valid && nasti.w_ready;
    assign b_fire    = (state_q == ST_B) && nasti.b_valid;

    // A mismatched r_last in either direction is a slave protocol error;
    // beat counting stays authoritative either way.
    assign r_proto_err = (nasti.r_id != id_q) || (nasti.r_last != last_beat);

    // ------------------------------------------------------------------
    // Constant and latched NASTI fields
    // ------------------------------------------------------------------
    assign nasti.ar_id     = id_q;
    assign nasti.ar_addr   = addr_q;
    assign nasti.ar_len    = len_q;
    assign nasti.ar_size   = size_q;
    assign nasti.ar_burst  = BURST_INCR;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'd0;
    assign nasti.ar_prot   = 3'd0;
    assign nasti.ar_qos    = 4'd0;
    assign nasti.ar_region = 4'd0;
    assign nasti.ar_user   = {USER_WIDTH{1'b0}};

    assign nasti.aw_id     = id_q;
    assign nasti.aw_addr   = addr_q;
    assign nasti.aw_len    = len_q;
    assign nasti.aw_size   = size_q;
    assign nasti.aw_burst  = BURST_INCR;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = 4'd0;
    assign nasti.aw_prot   = 3'd0;
    assign nasti.aw_qos    = 4'd0;
    assign nasti.aw_region = 4'd0;
    assign nasti.aw_user   = {USER_WIDTH{1'b0}};

    assign nasti.w_id      = id_q;
    assign nasti.w_data    = wd_data;
    assign nasti.w_strb    = wd_strb;
    assign nasti.w_user    = {USER_WIDTH{1'b0}};

    assign rd_data         = nasti.r_data;
    assign done_resp       = resp_q;
    assign done_err        = err_q;

    logic unused_user;
    assign unused_user = ^{nasti.r_user, nasti.b_user};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d        = state_q;
        cmd_ready      = 1'b0;
        wd_ready       = 1'b0;
        rd_valid       = 1'b0;
        rd_last        = 1'b0;
        done_valid     = 1'b0;
        nasti.ar_valid = 1'b0;
        nasti.aw_valid = 1'b0;
        nasti.w_valid  = 1'b0;
        nasti.w_last   = 1'b0;
        nasti.b_ready  = 1'b0;
        nasti.r_ready  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The state register already reads IDLE during reset, so
                // ready is masked until reset is released.
                cmd_ready = !rst;
                if (cmd_fire) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (chk_err)      state_d = ST_DONE;
                else if (write_q) state_d = ST_AW;
                else              state_d = ST_AR;
            end
            ST_AR: begin
                nasti.ar_valid = 1'b1;
                if (nasti.ar_ready) state_d = ST_R;
            end
            ST_R: begin
                rd_valid      = nasti.r_valid;
                rd_last       = last_beat;
                nasti.r_ready = rd_ready;
                if (r_fire && last_beat) state_d = ST_DONE;
            end
            ST_AW: begin
                nasti.aw_valid = 1'b1;
                if (nasti.aw_ready) state_d = ST_W;
            end
            ST_W: begin
                nasti.w_valid = wd_valid;
                nasti.w_last  = last_beat;
                wd_ready      = nasti.w_ready;
                if (w_fire && last_beat) state_d = ST_B;
            end
            ST_B: begin
                nasti.b_ready = 1'b1;
                if (b_fire) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, beat counter and response aggregation
    // ------------------------------------------------------------------
    // NOTE: the command fields are reset along with the control state so
    // the NASTI payload never shows X, even though it is only meaningful
    // while a valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            beat_q  <= '0;
            resp_q  <= RESP_OKAY;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        id_q    <= cmd_id;
                        addr_q  <= cmd_addr;
                        len_q   <= cmd_len;
                        size_q  <= cmd_size;
                        write_q <= cmd_write;
                    end
                end
                ST_CHK: begin
                    // Results of the previous command are held up to here.
                    resp_q <= chk_err ? RESP_SLVERR : RESP_OKAY;
                    err_q  <= chk_err;
                end
                ST_R: begin
                    if (r_fire) begin
                        beat_q <= beat_q + 8'd1;
                        resp_q <= max_resp(resp_q, nasti.r_resp);
                        if (r_proto_err) err_q <= 1'b1;
                    end
                end
                ST_W: begin
                    if (w_fire) beat_q <= beat_q + 8'd1;
                end
                ST_B: begin
                    if (b_fire) begin
                        resp_q <= nasti.b_resp;
                        if (nasti.b_id != id_q) err_q <= 1'b1;
                    end
                end
                ST_DONE: beat_q <= '0;
                default: ;
            endcase
        end
    end

endmodule
